// File: rtl/pow5_rr_credit_arbiter_pkg.sv
// rtl/pow5_rr_credit_arbiter_pkg.sv - width helpers and round-robin pick for the pow5 credit arbiter
package pow5_arb_pkg;

    function automatic int id_width(input int n_req);
        return $clog2(n_req);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Returns {found, index}: first valid index scanning ptr, ptr+1, ... modulo n_req (n_req <= 16).
    function automatic logic [4:0] rr_pick(input logic [15:0] valid, input logic [3:0] ptr, input int n_req);
        logic       found;
        logic [3:0] idx;
        int         cand;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < 16; k++) begin
            cand = int'(ptr) + k;
            if (cand >= n_req) cand = cand - n_req;
            if (k < n_req && !found && valid[cand[3:0]]) begin
                found = 1'b1;
                idx   = cand[3:0];
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/pow5_rr_credit_arbiter_if.sv
// rtl/pow5_rr_credit_arbiter_if.sv - requester, credit-return and pipeline-side signals of the arbiter
interface pow5_rr_credit_arbiter_if
    import pow5_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 10
);
    localparam int ID_W  = id_width(N_REQ);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [N_REQ*DATA_WIDTH-1:0] req_data_i;
    logic [N_REQ-1:0]            req_valid_i;
    logic [N_REQ-1:0]            req_ready_o;
    logic                        pop_i;
    logic [DATA_WIDTH-1:0]       pipe_data_o;
    logic                        pipe_valid_o;
    logic [ID_W-1:0]             pipe_id_o;
    logic [CNT_W-1:0]            credit_o;
    logic                        err_o;

    modport master (
        output req_data_i, req_valid_i, pop_i,
        input  req_ready_o, pipe_data_o, pipe_valid_o, pipe_id_o, credit_o, err_o
    );

    modport slave (
        input  req_data_i, req_valid_i, pop_i,
        output req_ready_o, pipe_data_o, pipe_valid_o, pipe_id_o, credit_o, err_o
    );
endinterface

// File: rtl/pow5_rr_credit_arbiter_credit_counter_sat.sv
// rtl/pow5_rr_credit_arbiter_credit_counter_sat.sv - FIFO credit counter with overflow guard and sticky error
module credit_counter_sat #(
    parameter int DEPTH = 10,
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             accept_i,
    input  logic             pop_i,
    output logic [CNT_W-1:0] credit_o,
    output logic             can_issue_o,
    output logic             err_o
);
    logic [CNT_W-1:0] r_credit;
    logic             r_err;
    logic             w_full;
    logic             w_pop_ok;

    assign w_full   = (r_credit == CNT_W'(DEPTH));
    assign w_pop_ok = pop_i && !w_full;

    // A pop while all credits are home would overflow the counter; drop it and flag the integrator.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_credit <= CNT_W'(DEPTH);
            r_err    <= 1'b0;
        end else begin
            if (accept_i && !w_pop_ok) begin
                r_credit <= r_credit - 1'b1;
            end else if (!accept_i && w_pop_ok) begin
                r_credit <= r_credit + 1'b1;
            end
            if (pop_i && w_full) begin
                r_err <= 1'b1;
            end
        end
    end

    assign credit_o    = r_credit;
    assign can_issue_o = (r_credit != '0);
    assign err_o       = r_err;
endmodule

// File: rtl/pow5_rr_credit_arbiter.sv
// rtl/pow5_rr_credit_arbiter.sv - round-robin, credit-gated admission of requester beats into the pow5 datapath
module pow5_rr_credit_arbiter
    import pow5_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 10
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    pow5_rr_credit_arbiter_if.slave bus
);
    localparam int ID_W  = id_width(N_REQ);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [ID_W-1:0]       r_ptr;
    logic [DATA_WIDTH-1:0] r_pipe_data;
    logic                  r_pipe_valid;
    logic [ID_W-1:0]       r_pipe_id;

    logic [4:0]            w_pick;
    logic                  w_found;
    logic [ID_W-1:0]       w_win;
    logic                  w_can_issue;
    logic                  w_accept;

    assign w_pick   = rr_pick(16'(bus.req_valid_i), 4'(r_ptr), N_REQ);
    assign w_found  = w_pick[4];
    assign w_win    = ID_W'(w_pick[3:0]);
    // Ready is held low during reset regardless of the counter state.
    assign w_accept = w_found && w_can_issue && !rst_i;

    assign bus.req_ready_o = w_accept ? (N_REQ'(1) << w_win) : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr        <= '0;
            r_pipe_data  <= '0;
            r_pipe_valid <= 1'b0;
            r_pipe_id    <= '0;
        end else begin
            r_pipe_valid <= w_accept;
            if (w_accept) begin
                r_pipe_data <= bus.req_data_i[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
                r_pipe_id   <= w_win;
                r_ptr       <= (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;
            end
        end
    end

    assign bus.pipe_data_o  = r_pipe_data;
    assign bus.pipe_valid_o = r_pipe_valid;
    assign bus.pipe_id_o    = r_pipe_id;

    credit_counter_sat #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_credit (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .accept_i    (w_accept),
        .pop_i       (bus.pop_i),
        .credit_o    (bus.credit_o),
        .can_issue_o (w_can_issue),
        .err_o       (bus.err_o)
    );
endmodule

// File: tb/tb_pow5_rr_credit_arbiter.sv
// tb/tb_pow5_rr_credit_arbiter.sv - bench for pow5_rr_credit_arbiter: per-cycle model compare plus directed literals
module tb_pow5_rr_credit_arbiter;
    localparam int N  = 4;
    localparam int DW = 4;
    localparam int D  = 10;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    pow5_rr_credit_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW), .DEPTH(D)) bus ();

    pow5_rr_credit_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .DEPTH(D)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: free credits, next-turn pointer, sticky error and last admitted beat.
    int m_credit;
    int m_ptr;
    int m_err;
    int m_pv;
    int m_pd;
    int m_pid;
    bit m_known = 1'b0;

    always @(negedge clk) begin
        int g;
        int idx;
        int exp_ready;
        g = -1;
        if (!rst && m_known && m_credit > 0) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && bus.req_valid_i[idx]) g = idx;
            end
        end
        exp_ready = (g >= 0) ? (1 << g) : 0;
        if (m_known) begin
            check("model_ready",      int'(bus.req_ready_o),  exp_ready);
            check("model_pipe_valid", int'(bus.pipe_valid_o), m_pv);
            check("model_pipe_data",  int'(bus.pipe_data_o),  m_pd);
            check("model_pipe_id",    int'(bus.pipe_id_o),    m_pid);
            check("model_credit",     int'(bus.credit_o),     m_credit);
            check("model_err",        int'(bus.err_o),        m_err);
        end
        if (rst) begin
            m_credit = D; m_ptr = 0; m_err = 0; m_pv = 0; m_pd = 0; m_pid = 0;
            m_known  = 1'b1;
        end else if (m_known) begin
            if (bus.pop_i) begin
                if (m_credit == D) m_err = 1;
                else               m_credit = m_credit + 1;
            end
            m_pv = (g >= 0) ? 1 : 0;
            if (g >= 0) begin
                m_pd     = int'((bus.req_data_i >> (g * DW)) & 16'hF);
                m_pid    = g;
                m_ptr    = (g + 1) % N;
                m_credit = m_credit - 1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid_i = 4'b1111;
        bus.req_data_i  = 16'h9C53;
        bus.pop_i       = 1'b0;
        @(negedge clk);
        check("ready_during_reset", int'(bus.req_ready_o), 0);
        cyc(); cyc();

        // Single requester 1 with data 0x3
        rst = 1'b0;
        bus.req_valid_i = 4'b0010;
        bus.req_data_i  = 16'h0030;
        @(negedge clk);
        check("t1_ready", int'(bus.req_ready_o), 2);
        check("t1_credit_before", int'(bus.credit_o), 10);
        check("t1_err_reset", int'(bus.err_o), 0);
        cyc();
        bus.req_valid_i = 4'b0000;
        @(negedge clk);
        check("t1_pipe_valid", int'(bus.pipe_valid_o), 1);
        check("t1_pipe_data", int'(bus.pipe_data_o), 3);
        check("t1_pipe_id", int'(bus.pipe_id_o), 1);
        check("t1_credit_after", int'(bus.credit_o), 9);

        // All requesters valid until credits run out
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.req_valid_i = 4'b1111;
        bus.req_data_i  = 16'h9C53;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t2_rotation", int'(bus.req_ready_o), 1 << (k % 4));
            cyc();
        end
        @(negedge clk);
        check("t2_credit_empty", int'(bus.credit_o), 0);
        check("t2_ready_blocked", int'(bus.req_ready_o), 0);
        cyc();
        @(negedge clk);
        check("t2_pipe_idle", int'(bus.pipe_valid_o), 0);

        // One pop at zero credit admits exactly one beat, no bypass
        cyc();
        bus.pop_i = 1'b1;
        @(negedge clk);
        check("t3_no_bypass", int'(bus.req_ready_o), 0);
        cyc();
        bus.pop_i = 1'b0;
        @(negedge clk);
        check("t3_credit_one", int'(bus.credit_o), 1);
        check("t3_ready_ptr2", int'(bus.req_ready_o), 4);
        cyc();
        @(negedge clk);
        check("t3_credit_zero", int'(bus.credit_o), 0);
        check("t3_pipe_id", int'(bus.pipe_id_o), 2);
        check("t3_pipe_data", int'(bus.pipe_data_o), 12);

        // Refill to 7, then accept and pop together every cycle
        cyc();
        bus.req_valid_i = 4'b0000;
        bus.pop_i = 1'b1;
        repeat (7) cyc();
        bus.req_valid_i = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t4_credit_steady", int'(bus.credit_o), 7);
            check("t4_rotation", int'(bus.req_ready_o), 1 << ((3 + k) % 4));
            cyc();
        end
        bus.req_valid_i = 4'b0000;
        bus.pop_i = 1'b0;

        // Pop with all credits home, then reset mid-stream
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.pop_i = 1'b1;
        cyc();
        bus.pop_i = 1'b0;
        @(negedge clk);
        check("t5_credit_held", int'(bus.credit_o), 10);
        check("t5_err_set", int'(bus.err_o), 1);
        bus.req_valid_i = 4'b1111;
        repeat (6) cyc();
        bus.req_valid_i = 4'b0000;
        @(negedge clk);
        check("t5_credit_four", int'(bus.credit_o), 4);
        check("t5_err_sticky", int'(bus.err_o), 1);
        cyc();
        rst = 1'b1;
        bus.req_valid_i = 4'b1111;
        @(negedge clk);
        check("t6_ready_in_reset", int'(bus.req_ready_o), 0);
        cyc();
        rst = 1'b0;
        bus.req_valid_i = 4'b1010;
        @(negedge clk);
        check("t6_credit_reset", int'(bus.credit_o), 10);
        check("t6_pipe_valid_reset", int'(bus.pipe_valid_o), 0);
        check("t6_err_cleared", int'(bus.err_o), 0);
        check("t6_first_grant", int'(bus.req_ready_o), 2);
        cyc();
        bus.req_valid_i = 4'b0000;
        @(negedge clk);
        check("t6_pipe_id", int'(bus.pipe_id_o), 1);
        check("t6_pipe_data", int'(bus.pipe_data_o), 5);
        repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pow5_rr_credit_arbiter.md
Name: pow5_rr_credit_arbiter

Overview:
Shares one credit-controlled pow5 pipeline/FIFO datapath among N_REQ valid/ready requesters. Each cycle it selects one requester by round-robin and admits one beat only if a FIFO credit is free. It tracks credits internally from the downstream pop strobe. The admitted beat is registered and tagged with a source ID, so the downstream can route results back to their requesters.

Parameters:
N_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 4, width of one requester data word
DEPTH, 10, FIFO depth; equals the number of credits
ID_W (localparam), $clog2(N_REQ), width of source ID
CNT_W (localparam), $clog2(DEPTH+1), width of credit counter

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
req_data_i  in  N_REQ*DATA_WIDTH  requester i data in slice [i*DATA_WIDTH +: DATA_WIDTH]
req_valid_i  in  N_REQ  per-requester valid
req_ready_o  out  N_REQ  per-requester ready, one-hot or zero
pop_i  in  1  downstream FIFO pop (ready_i & valid_o), returns one credit
pipe_data_o  out  DATA_WIDTH  admitted data, to pow5 pipeline input
pipe_valid_o  out  1  admitted-beat strobe, to pow5 data_valid_i
pipe_id_o  out  ID_W  source index of admitted beat
credit_o  out  CNT_W  current free credits
err_o  out  1  sticky: pop_i seen while credit_o == DEPTH

Behaviour:
- Reset, sync active-high: credit = DEPTH; rr pointer = 0; pipe_valid_o = 0; pipe_data_o = 0; pipe_id_o = 0; err_o = 0. req_ready_o = 0 while rst_i = 1.
- can_issue = (credit != 0). There is no same-cycle bypass: a pop_i in cycle t frees a credit usable from t+1.
- Grant selection is combinational:
  - Scan indices ptr, ptr+1, ..., ptr+N_REQ-1 (mod N_REQ).
  - The first index with req_valid_i set is the winner.
  - If there is no valid requester, or can_issue = 0, there is no grant.
- req_ready_o[w] = 1 only for winner w when can_issue = 1; all other bits are 0. Ready may depend on valid.
- accept = any req_valid_i & can_issue. A beat is transferred on requester w when req_valid_i[w] & req_ready_o[w].
- On accept: ptr <= (w+1) mod N_REQ. Without accept, ptr holds.
- Output register, 1-cycle latency:
  - On accept, pipe_data_o <= slice w, pipe_id_o <= w, and pipe_valid_o <= 1 in the next cycle.
  - Otherwise pipe_valid_o <= 0 and data/id hold their last values.
- Credit update: credit <= credit - accept + (pop_i & credit != DEPTH).
  - Accept and pop in the same cycle leave credit unchanged.
  - Credit never underflows, because accept requires credit != 0.
- Overflow guard: pop_i with credit == DEPTH is ignored (credit holds) and sets err_o. err_o clears only on reset.
- credit_o shows the registered counter value.
- Requester rules:
  - Requesters must hold data and valid until their ready is seen.
  - A requester that drops valid without a handshake just loses the turn; the pointer does not advance.
- Reset mid-operation: all state returns to reset values on the next edge. Beats already in the pipeline or FIFO are not tracked; the integrator resets the whole datapath together.
- Fairness: with all requesters continuously valid and credit available, grants rotate 0,1,2,...,N_REQ-1,0. No requester waits more than N_REQ-1 accepts.

Decomposition:
- Package pow5_arb_pkg: function rr_pick(valid, ptr) returning {found, index}, and the localparam width formulas.
- One sub-module, credit_counter_sat: the credit counter with saturation, the error flag and the credit_o output.
- The round-robin pick and output register stay in the top module.

Test Plan:
- Reset, then one requester (1) valid with data 0x3, pop_i = 0 -> req_ready_o = 4'b0010 in the same cycle; next cycle pipe_valid_o = 1, pipe_data_o = 0x3, pipe_id_o = 1; credit_o goes 10 -> 9.
- All 4 requesters valid continuously, pop_i = 0 -> grants go 0,1,2,3,0,... for 10 cycles; credit_o reaches 0; all req_ready_o = 0 afterwards with pipe_valid_o = 0.
- Credit = 0, pulse pop_i for 1 cycle -> credit_o = 1 the next cycle; exactly one grant one cycle after that; credit_o back to 0.
- Steady state with accept and pop_i both set every cycle -> credit_o stays constant (e.g. 7); one grant per cycle in rotating order.
- pop_i = 1 directly after reset (credit = 10) -> credit_o stays 10; err_o = 1 and sticky until rst_i.
- Reset asserted mid-stream at credit = 4, ptr = 2 -> next cycle credit_o = 10, pipe_valid_o = 0, err_o = 0; first post-reset grant goes to the lowest valid index from 0.
